// File: rtl/cond_pkg.sv
// Shared definitions for branch resolution: condition codes, FSM states and
// the PC-relative branch target helper.
package cond_pkg;

    localparam int unsigned COND_W = 4;

    localparam logic [COND_W-1:0] COND_NOP = 4'd0;
    localparam logic [COND_W-1:0] COND_E   = 4'd1;
    localparam logic [COND_W-1:0] COND_NE  = 4'd2;
    localparam logic [COND_W-1:0] COND_L   = 4'd3;
    localparam logic [COND_W-1:0] COND_G   = 4'd4;
    localparam logic [COND_W-1:0] COND_LE  = 4'd5;
    localparam logic [COND_W-1:0] COND_GE  = 4'd6;
    localparam logic [COND_W-1:0] COND_J   = 4'd7;
    localparam logic [COND_W-1:0] COND_JR  = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_FLUSH    = 2'd2
    } br_state_t;

    // pc + 4 + (sext(imm16) << 2), wrapping at 32 bits
    function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                  input logic [15:0] imm16);
        return pc + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational condition evaluator: decides whether a decoded branch/jump is
// taken and flags codes that are no-ops.
module branch_cond_eval
    import cond_pkg::*;
(
    input  logic [COND_W-1:0] cond,
    input  logic [31:0]       rs_val,
    input  logic [31:0]       rt_val,
    output logic              take,
    output logic              is_nop
);

    logic rs_neg;
    logic rs_zero;

    assign rs_neg  = rs_val[31];
    assign rs_zero = (rs_val == 32'd0);

    always_comb begin
        take   = 1'b0;
        is_nop = 1'b0;
        case (cond)
            COND_E:  take = (rs_val == rt_val);
            COND_NE: take = (rs_val != rt_val);
            COND_L:  take = rs_neg;
            COND_G:  take = !rs_neg && !rs_zero;
            COND_LE: take = rs_neg || rs_zero;
            COND_GE: take = !rs_neg;
            COND_J:  take = 1'b1;
            COND_JR: take = 1'b1;
            default: is_nop = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: evaluates the condition, issues a held
// redirect to fetch, then flushes younger stages for FLUSH_CYCLES cycles.
module branch_resolve
    import cond_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [COND_W-1:0] cond,
    input  logic [31:0]       inst,
    input  logic [31:0]       pc,
    input  logic [31:0]       rs_val,
    input  logic [31:0]       rt_val,
    output logic              redirect_valid,
    input  logic              redirect_ready,
    output logic [31:0]       redirect_pc,
    output logic              taken,
    output logic              flush,
    output logic [CNT_W-1:0]  br_count,
    output logic [CNT_W-1:0]  taken_count
);

    localparam int unsigned FC_W = 4;

    br_state_t   state;
    logic [FC_W-1:0] flush_cnt;

    logic        take;
    logic        is_nop;
    logic        accept;
    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic        unused_inst;

    assign unused_inst = ^inst[31:26];

    branch_cond_eval u_eval (
        .cond   (cond),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .take   (take),
        .is_nop (is_nop)
    );

    // in_ready is a pure decode of the state register
    assign in_ready = (state == ST_IDLE);
    assign accept   = in_valid && in_ready;
    assign pc_plus4 = pc + 32'd4;

    always_comb begin
        target = branch_target(pc, inst[15:0]);
        case (cond)
            COND_J:  target = {pc_plus4[31:28], inst[25:0], 2'b00};
            COND_JR: target = rs_val;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            flush_cnt      <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            taken          <= 1'b0;
            flush          <= 1'b0;
            br_count       <= '0;
            taken_count    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        taken <= take;
                        if (!is_nop && (br_count != '1))
                            br_count <= br_count + CNT_W'(1);
                        if (take) begin
                            if (taken_count != '1)
                                taken_count <= taken_count + CNT_W'(1);
                            redirect_pc    <= target;
                            redirect_valid <= 1'b1;
                            state          <= ST_REDIRECT;
                        end
                    end
                end
                ST_REDIRECT: begin
                    // redirect_pc stays frozen until fetch takes it
                    if (redirect_ready) begin
                        redirect_valid <= 1'b0;
                        flush          <= 1'b1;
                        flush_cnt      <= FC_W'(FLUSH_CYCLES);
                        state          <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == FC_W'(1)) begin
                        flush <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        flush_cnt <= flush_cnt - FC_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed plan steps plus random ops, checked
// against a reference model; a second instance with 4-bit counters covers saturation.
module tb_branch_resolve;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [3:0]  cond;
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        redirect_ready;

    logic        in_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        taken;
    logic        flush;
    logic [15:0] br_count;
    logic [15:0] taken_count;

    logic        s_in_ready;
    logic        s_redirect_valid;
    logic [31:0] s_redirect_pc;
    logic        s_taken;
    logic        s_flush;
    logic [3:0]  s_br_count;
    logic [3:0]  s_taken_count;

    int errors = 0;
    int checks = 0;
    int br_n   = 0;
    int tk_n   = 0;

    always #5 clk = ~clk;

    branch_resolve #(.FLUSH_CYCLES(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .cond(cond), .inst(inst), .pc(pc), .rs_val(rs_val), .rt_val(rt_val),
        .redirect_valid(redirect_valid), .redirect_ready(redirect_ready),
        .redirect_pc(redirect_pc), .taken(taken), .flush(flush),
        .br_count(br_count), .taken_count(taken_count)
    );

    branch_resolve #(.FLUSH_CYCLES(2), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .cond(cond), .inst(inst), .pc(pc), .rs_val(rs_val), .rt_val(rt_val),
        .redirect_valid(s_redirect_valid), .redirect_ready(redirect_ready),
        .redirect_pc(s_redirect_pc), .taken(s_taken), .flush(s_flush),
        .br_count(s_br_count), .taken_count(s_taken_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int n, input int maxv);
        return (n > maxv) ? maxv : n;
    endfunction

    // Reference: outcome straight from the condition rules
    function automatic logic ref_take(input int c, input logic [31:0] rs, input logic [31:0] rt);
        int signed rsi;
        rsi = $signed(rs);
        case (c)
            1: return rs == rt;
            2: return rs != rt;
            3: return rsi < 0;
            4: return rsi > 0;
            5: return rsi <= 0;
            6: return rsi >= 0;
            7, 8: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_target(input int c, input logic [31:0] ins,
                                               input logic [31:0] p, input logic [31:0] rs);
        logic [31:0] off;
        case (c)
            7: return ((p + 32'd4) & 32'hF000_0000) | ({6'd0, ins[25:0]} * 32'd4);
            8: return rs;
            default: begin
                off = 32'($signed(ins[15:0])) * 32'd4;
                return p + 32'd4 + off;
            end
        endcase
    endfunction

    task automatic chk_counts();
        chk("br_count", 32'(br_count), 32'(sat(br_n, 65535)));
        chk("taken_count", 32'(taken_count), 32'(sat(tk_n, 65535)));
        chk("sat_br_count", 32'(s_br_count), 32'(sat(br_n, 15)));
        chk("sat_taken_count", 32'(s_taken_count), 32'(sat(tk_n, 15)));
    endtask

    // Called at a negedge, returns at a negedge with the block back in IDLE
    task automatic send(input int c, input logic [31:0] ins, input logic [31:0] p,
                        input logic [31:0] rs, input logic [31:0] rt,
                        input int ack_delay, input bit hold);
        logic        t;
        logic [31:0] tgt;
        int          n;
        t   = ref_take(c, rs, rt);
        tgt = ref_target(c, ins, p, rs);
        cond = 4'(c); inst = ins; pc = p; rs_val = rs; rt_val = rt;
        in_valid = 1'b1;
        chk("in_ready_pre", 32'(in_ready), 32'd1);
        @(negedge clk);
        if (c >= 1 && c <= 8) br_n++;
        if (t) tk_n++;
        in_valid = hold;
        chk("taken", 32'(taken), 32'(t));
        chk("redirect_valid", 32'(redirect_valid), 32'(t));
        if (t) begin
            chk("redirect_pc", redirect_pc, tgt);
            repeat (ack_delay) begin
                @(negedge clk);
                chk("redirect_hold_valid", 32'(redirect_valid), 32'd1);
                chk("redirect_hold_pc", redirect_pc, tgt);
                chk("flush_during_redirect", 32'(flush), 32'd0);
            end
            redirect_ready = 1'b1;
            @(negedge clk);
            redirect_ready = 1'b0;
            chk("redirect_dropped", 32'(redirect_valid), 32'd0);
            n = 0;
            while (flush === 1'b1 && n < 40) begin
                n++;
                @(negedge clk);
            end
            chk("flush_cycles", 32'(n), 32'd2);
            in_valid = 1'b0;
            chk("in_ready_post", 32'(in_ready), 32'd1);
        end else begin
            chk("in_ready_nt", 32'(in_ready), 32'd1);
        end
        chk_counts();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        br_n  = 0;
        tk_n  = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] rs, rt;
        rst_n = 1'b0; in_valid = 1'b0; cond = '0; inst = '0; pc = '0;
        rs_val = '0; rt_val = '0; redirect_ready = 1'b0;
        do_reset();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_taken", 32'(taken), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk_counts();

        // BEQ taken with a 3-cycle stall on the redirect
        send(1, 32'h0000_0004, 32'h0000_0100, 32'd5, 32'd5, 3, 1'b0);
        // BNE not taken, back-to-back
        send(2, 32'h0000_0010, 32'h0000_0200, 32'd7, 32'd7, 0, 1'b0);
        send(2, 32'h0000_0010, 32'h0000_0204, 32'd7, 32'd7, 0, 1'b0);
        // signed compares against zero
        send(3, 32'h0000_0008, 32'h0000_0300, 32'hFFFF_FFFF, 32'd0, 1, 1'b0);
        send(4, 32'h0000_0008, 32'h0000_0300, 32'hFFFF_FFFF, 32'd0, 0, 1'b0);
        send(6, 32'h0000_FFFE, 32'h0000_0400, 32'd0, 32'd9, 0, 1'b0);
        chk("ge_back_pc", redirect_pc, 32'h0000_03FC);
        // jumps and an out-of-range code
        send(7, 32'h0000_0040, 32'hF000_0000, 32'd0, 32'd0, 2, 1'b0);
        chk("j_pc", redirect_pc, 32'hF000_0100);
        send(8, 32'h0000_0000, 32'h0000_1000, 32'h0040_0020, 32'd0, 0, 1'b0);
        chk("jr_pc", redirect_pc, 32'h0040_0020);
        send(12, 32'h0000_0004, 32'h0000_1000, 32'd1, 32'd1, 0, 1'b0);

        // reset while flushing
        cond = 4'd1; rs_val = 32'd1; rt_val = 32'd1; inst = 32'd4; pc = 32'h500;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        redirect_ready = 1'b1;
        @(negedge clk);
        redirect_ready = 1'b0;
        chk("mid_flush_high", 32'(flush), 32'd1);
        #2 rst_n = 1'b0;
        br_n = 0; tk_n = 0;
        #1;
        chk("async_flush", 32'(flush), 32'd0);
        chk("async_redirect_valid", 32'(redirect_valid), 32'd0);
        chk("async_redirect_pc", redirect_pc, 32'd0);
        chk("async_taken", 32'(taken), 32'd0);
        chk_counts();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_flush", 32'(flush), 32'd0);
        chk("post_rst_redirect", 32'(redirect_valid), 32'd0);

        // random ops against the model
        for (int i = 0; i < 60; i++) begin
            rs = ($urandom_range(0, 3) == 0) ? 32'd0 :
                 ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 1) ? -1 : 1) : $urandom;
            rt = ($urandom_range(0, 1) == 0) ? rs : $urandom;
            send(int'($urandom_range(0, 15)), $urandom, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                 rs, rt, int'($urandom_range(0, 3)), 1'b0);
        end

        // saturation: 20 taken jumps with in_valid held through redirect/flush
        do_reset();
        for (int i = 0; i < 20; i++)
            send(7, 32'(i), 32'h0000_2000, 32'd0, 32'd0, int'($urandom_range(0, 2)), 1'b1);
        chk("sat_br_final", 32'(s_br_count), 32'd15);
        chk("sat_taken_final", 32'(s_taken_count), 32'd15);
        chk("wide_br_final", 32'(br_count), 32'd20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
